mips_register_file: RTL and testbench

General-purpose register file of the 32-bit single-cycle MIPS datapath: 32 entries of 32 bits, two combinational read ports addressed by instruction fields rs/rt, and one clocked write port. It sits directly downstream of the rt/rd destination-select multiplexer, whose 5-bit result drives `write_reg`. It is upstream of the ALU operand path and the store-data path. Register 0 is hardwired to zero.

---
 rtl/mips_register_file_if.sv | 23 ++
 rtl/mips_register_file.sv | 74 +++++++
 tb/tb_mips_register_file.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/mips_register_file_if.sv
// Register-file access bundle: two read ports (rs/rt) and one write port.
// The datapath side is the master and the register file is the slave.
interface mips_register_file_if #(
    parameter int DATA_WIDTH = 32
);
    logic [4:0]            read_reg1;
    logic [4:0]            read_reg2;
    logic [4:0]            write_reg;
    logic [DATA_WIDTH-1:0] write_data;
    logic                  reg_write;
    logic [DATA_WIDTH-1:0] read_data1;
    logic [DATA_WIDTH-1:0] read_data2;

    modport master (
        output read_reg1, read_reg2, write_reg, write_data, reg_write,
        input  read_data1, read_data2
    );

    modport slave (
        input  read_reg1, read_reg2, write_reg, write_data, reg_write,
        output read_data1, read_data2
    );
endinterface

// File: rtl/mips_register_file.sv
// 32x32 MIPS register file, $zero hardwired, two combinational reads, one clocked write.
// Define REGFILE_BYPASS_EN to forward write_data to a read port addressing the register being written.

// One storage register; reset has priority over a write in the same cycle.
module mips_rf_entry #(
    parameter int                    DATA_WIDTH  = 32,
    parameter logic [DATA_WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  we,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic [DATA_WIDTH-1:0] q
);
    always_ff @(posedge clk) begin
        if (reset)
            q <= RESET_VALUE;
        else if (we)
            q <= wdata;
    end
endmodule

module mips_register_file #(
    parameter int                    DATA_WIDTH  = 32,
    parameter logic [DATA_WIDTH-1:0] RESET_VALUE = 32'h0000_0000
) (
    input  logic                 clk,
    input  logic                 reset,
    mips_register_file_if.slave  rf
);
    localparam int NUM_REGS = 32;

    logic [NUM_REGS-1:0][DATA_WIDTH-1:0] regs;
    logic [NUM_REGS-1:0]                 we;

    // Entry 0 has no storage, so every read of it sees zero.
    assign regs[0] = '0;
    assign we[0]   = 1'b0;

    for (genvar i = 1; i < NUM_REGS; i++) begin : g_reg
        assign we[i] = rf.reg_write && (rf.write_reg == 5'(i));

        mips_rf_entry #(
            .DATA_WIDTH  (DATA_WIDTH),
            .RESET_VALUE (RESET_VALUE)
        ) u_entry (
            .clk   (clk),
            .reset (reset),
            .we    (we[i]),
            .wdata (rf.write_data),
            .q     (regs[i])
        );
    end

`ifdef REGFILE_BYPASS_EN
    logic wr_fwd;
    assign wr_fwd = rf.reg_write && !reset && (rf.write_reg != 5'd0);

    always_comb begin
        rf.read_data1 = regs[rf.read_reg1];
        rf.read_data2 = regs[rf.read_reg2];
        if (wr_fwd && (rf.read_reg1 == rf.write_reg))
            rf.read_data1 = rf.write_data;
        if (wr_fwd && (rf.read_reg2 == rf.write_reg))
            rf.read_data2 = rf.write_data;
    end
`else
    // Stored contents only; outputs never depend on the write port.
    always_comb begin
        rf.read_data1 = regs[rf.read_reg1];
        rf.read_data2 = regs[rf.read_reg2];
    end
`endif
endmodule

// File: tb/tb_mips_register_file.sv
// Directed bench for mips_register_file: default-reset DUT plus a DEADBEEF-reset DUT fed identically.
module tb_mips_register_file;
    logic clk = 1'b0;
    logic reset;
    int   tests = 0;
    int   fails = 0;

    always #5 clk = ~clk;

    mips_register_file_if #(.DATA_WIDTH(32)) rf  ();
    mips_register_file_if #(.DATA_WIDTH(32)) rf2 ();

    assign rf2.read_reg1  = rf.read_reg1;
    assign rf2.read_reg2  = rf.read_reg2;
    assign rf2.write_reg  = rf.write_reg;
    assign rf2.write_data = rf.write_data;
    assign rf2.reg_write  = rf.reg_write;

    mips_register_file #(.DATA_WIDTH(32), .RESET_VALUE(32'h0000_0000)) u_dut (
        .clk   (clk),
        .reset (reset),
        .rf    (rf.slave)
    );

    mips_register_file #(.DATA_WIDTH(32), .RESET_VALUE(32'hDEAD_BEEF)) u_dut_rv (
        .clk   (clk),
        .reset (reset),
        .rf    (rf2.slave)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [4:0] a, input logic [31:0] d);
        rf.reg_write  = 1'b1;
        rf.write_reg  = a;
        rf.write_data = d;
        tick();
        rf.reg_write  = 1'b0;
    endtask

    initial begin
        logic [31:0] hz_exp;
        reset         = 1'b1;
        rf.reg_write  = 1'b0;
        rf.write_reg  = 5'd0;
        rf.write_data = 32'h0;
        rf.read_reg1  = 5'd0;
        rf.read_reg2  = 5'd0;

        // Reset then read-all on both reset-value variants
        @(negedge clk);
        tick();
        reset = 1'b0;
        for (int a = 0; a < 32; a++) begin
            rf.read_reg1 = 5'(a);
            rf.read_reg2 = 5'(31 - a);
            #1;
            chk($sformatf("rst_p1_r%0d", a), rf.read_data1, 32'h0);
            chk($sformatf("rst_p2_r%0d", 31 - a), rf.read_data2, 32'h0);
            chk($sformatf("rstv_p1_r%0d", a), rf2.read_data1, (a == 0) ? 32'h0 : 32'hDEAD_BEEF);
            chk($sformatf("rstv_p2_r%0d", 31 - a), rf2.read_data2, (a == 31) ? 32'h0 : 32'hDEAD_BEEF);
        end

        // Write/readback on consecutive edges
        wr(5'd8, 32'h1234_5678);
        wr(5'd31, 32'hFFFF_0001);
        rf.read_reg1 = 5'd8;
        rf.read_reg2 = 5'd31;
        #1;
        chk("wb_r8", rf.read_data1, 32'h1234_5678);
        chk("wb_r31", rf.read_data2, 32'hFFFF_0001);
        for (int a = 0; a < 32; a++) begin
            if (a == 8 || a == 31) continue;
            rf.read_reg1 = 5'(a);
            #1;
            chk($sformatf("wb_other_r%0d", a), rf.read_data1, 32'h0);
            chk($sformatf("wbv_other_r%0d", a), rf2.read_data1, (a == 0) ? 32'h0 : 32'hDEAD_BEEF);
        end

        // $zero protection, including no bypass onto address 0
        rf.read_reg1  = 5'd0;
        rf.read_reg2  = 5'd0;
        rf.reg_write  = 1'b1;
        rf.write_reg  = 5'd0;
        rf.write_data = 32'hAAAA_AAAA;
        #1;
        chk("zero_pre_p1", rf.read_data1, 32'h0);
        tick();
        rf.reg_write = 1'b0;
        chk("zero_p1", rf.read_data1, 32'h0);
        chk("zero_p2", rf.read_data2, 32'h0);

        // Enable gating
        wr(5'd5, 32'h0000_0007);
        rf.reg_write  = 1'b0;
        rf.write_reg  = 5'd5;
        rf.write_data = 32'h5555_5555;
        rf.read_reg1  = 5'd5;
        rf.read_reg2  = 5'd5;
        tick();
        chk("gate_p1", rf.read_data1, 32'h0000_0007);
        chk("gate_p2", rf.read_data2, 32'h0000_0007);

        // Same-cycle hazard on reg 9
        wr(5'd9, 32'h1);
        rf.read_reg1  = 5'd9;
        rf.read_reg2  = 5'd8;
        rf.reg_write  = 1'b1;
        rf.write_reg  = 5'd9;
        rf.write_data = 32'h2;
        #1;
`ifdef REGFILE_BYPASS_EN
        hz_exp = 32'h2;
`else
        hz_exp = 32'h1;
`endif
        chk("hz_pre_p1", rf.read_data1, hz_exp);
        chk("hz_pre_p2_other", rf.read_data2, 32'h1234_5678);
        tick();
        rf.reg_write = 1'b0;
        chk("hz_post_p1", rf.read_data1, 32'h2);

        // Back-to-back writes: last edge wins, neighbour untouched
        wr(5'd10, 32'h0000_000A);
        wr(5'd10, 32'h0000_000B);
        rf.read_reg1 = 5'd10;
        rf.read_reg2 = 5'd11;
        #1;
        chk("b2b_r10", rf.read_data1, 32'h0000_000B);
        chk("b2b_r11", rf.read_data2, 32'h0);

        // Reset vs write collision
        wr(5'd3, 32'h0000_CAFE);
        rf.read_reg1  = 5'd3;
        rf.read_reg2  = 5'd8;
        reset         = 1'b1;
        rf.reg_write  = 1'b1;
        rf.write_reg  = 5'd3;
        rf.write_data = 32'h0000_BEEF;
        #1;
        chk("col_pre_p1", rf.read_data1, 32'h0000_CAFE);
        chk("col_pre_v_p1", rf2.read_data1, 32'h0000_CAFE);
        chk("col_pre_p2", rf.read_data2, 32'h1234_5678);
        tick();
        reset        = 1'b0;
        rf.reg_write = 1'b0;
        chk("col_post_p1", rf.read_data1, 32'h0);
        chk("col_post_v_p1", rf2.read_data1, 32'hDEAD_BEEF);
        chk("col_post_p2", rf.read_data2, 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
